// File: rtl/ocs_tx_arbiter_if.sv
// 64-bit AXI-Stream bundle shared by the three OCS TX requesters and the MAC-side output.
interface ocs_tx_arbiter_if;
  logic        tvalid;
  logic [63:0] tdata;
  logic        tlast;
  logic [7:0]  tkeep;
  logic        tuser;
  logic        tready;

  modport master (output tvalid, tdata, tlast, tkeep, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tkeep, tuser, output tready);
endinterface

// File: rtl/ocs_tx_arbiter.sv
// Frame-atomic fixed-priority (S0>S1>S2) arbiter for the OCS TX AXIS port with slot guard and watchdog.
// Optional statistics counters are enabled by defining OCS_TX_ARB_STAT_EN.
module ocs_tx_arbiter #(
  parameter logic [15:0] P_SLOT_LEN  = 16'd1000,
  parameter logic [15:0] P_GUARD_LEN = 16'd32,
  parameter logic [15:0] P_MAX_BEATS = 16'd256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_new_slot_start,
  input  logic              i_data_en,
  ocs_tx_arbiter_if.slave   s0_axis,
  ocs_tx_arbiter_if.slave   s1_axis,
  ocs_tx_arbiter_if.slave   s2_axis,
  ocs_tx_arbiter_if.master  m_axis,
  output logic [1:0]        o_grant,
  output logic              o_abort
`ifdef OCS_TX_ARB_STAT_EN
  ,
  output logic [15:0]       o_frame_cnt0,
  output logic [15:0]       o_frame_cnt1,
  output logic [15:0]       o_frame_cnt2,
  output logic [15:0]       o_abort_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ABORT
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'd3;

  state_t      state;
  logic [15:0] slot_cnt;
  logic [15:0] beat_cnt;
  logic [15:0] beat_next;

  logic        sel_valid;
  logic [63:0] sel_data;
  logic        sel_last;
  logic [7:0]  sel_keep;
  logic        sel_user;
  logic        src_ready;
  logic        accept;
  logic        s2_eligible;

  assign s2_eligible = i_data_en && (slot_cnt < (P_SLOT_LEN - P_GUARD_LEN));

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_keep  = '0;
    sel_user  = 1'b0;
    case (o_grant)
      2'd0: begin
        sel_valid = s0_axis.tvalid;
        sel_data  = s0_axis.tdata;
        sel_last  = s0_axis.tlast;
        sel_keep  = s0_axis.tkeep;
        sel_user  = s0_axis.tuser;
      end
      2'd1: begin
        sel_valid = s1_axis.tvalid;
        sel_data  = s1_axis.tdata;
        sel_last  = s1_axis.tlast;
        sel_keep  = s1_axis.tkeep;
        sel_user  = s1_axis.tuser;
      end
      2'd2: begin
        sel_valid = s2_axis.tvalid;
        sel_data  = s2_axis.tdata;
        sel_last  = s2_axis.tlast;
        sel_keep  = s2_axis.tkeep;
        sel_user  = s2_axis.tuser;
      end
      default: ;
    endcase
  end

  // While aborting, the owner is drained at full rate regardless of the MAC.
  assign src_ready = (state == ABORT) || ((state == BUSY) && m_axis.tready);
  assign accept    = sel_valid && src_ready;
  assign beat_next = beat_cnt + 16'd1;

  assign m_axis.tvalid = (state == BUSY) && sel_valid;
  assign m_axis.tdata  = sel_data;
  assign m_axis.tlast  = sel_last;
  assign m_axis.tkeep  = sel_keep;
  assign m_axis.tuser  = sel_user;

  assign s0_axis.tready = (o_grant == 2'd0) && src_ready;
  assign s1_axis.tready = (o_grant == 2'd1) && src_ready;
  assign s2_axis.tready = (o_grant == 2'd2) && src_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_cnt <= '0;
    end else if (i_new_slot_start) begin
      slot_cnt <= '0;
    end else if (slot_cnt < P_SLOT_LEN) begin
      slot_cnt <= slot_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      o_grant  <= GRANT_NONE;
      o_abort  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      o_abort <= 1'b0;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (s0_axis.tvalid) begin
            o_grant <= 2'd0;
            state   <= BUSY;
          end else if (s1_axis.tvalid) begin
            o_grant <= 2'd1;
            state   <= BUSY;
          end else if (s2_axis.tvalid && s2_eligible) begin
            o_grant <= 2'd2;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (accept) begin
            if (sel_last) begin
              state    <= IDLE;
              o_grant  <= GRANT_NONE;
              beat_cnt <= '0;
            end else if (beat_next == P_MAX_BEATS - 16'd1) begin
              // P_MAX_BEATS-1 beats have reached the MAC without tlast: cut the frame here.
              state    <= ABORT;
              o_abort  <= 1'b1;
              beat_cnt <= beat_next;
            end else begin
              beat_cnt <= beat_next;
            end
          end
        end
        ABORT: begin
          if (accept && sel_last) begin
            state    <= IDLE;
            o_grant  <= GRANT_NONE;
            beat_cnt <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          o_grant <= GRANT_NONE;
        end
      endcase
    end
  end

`ifdef OCS_TX_ARB_STAT_EN
  logic frame_done;
  assign frame_done = (state == BUSY) && accept && sel_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_cnt0 <= '0;
      o_frame_cnt1 <= '0;
      o_frame_cnt2 <= '0;
      o_abort_cnt  <= '0;
    end else begin
      if (frame_done && (o_grant == 2'd0)) o_frame_cnt0 <= o_frame_cnt0 + 16'd1;
      if (frame_done && (o_grant == 2'd1)) o_frame_cnt1 <= o_frame_cnt1 + 16'd1;
      if (frame_done && (o_grant == 2'd2)) o_frame_cnt2 <= o_frame_cnt2 + 16'd1;
      if ((state == BUSY) && accept && !sel_last && (beat_next == P_MAX_BEATS - 16'd1)) begin
        o_abort_cnt <= o_abort_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
